// File: rtl/coax_rx_byte_stream.sv
// Unpacks 10-bit words from a first-word-fall-through receive buffer into a
// two-byte-per-word stream; an upstream error emits a marker/code record and halts.
module coax_rx_byte_stream #(
    parameter logic [7:0] ERROR_MARKER = 8'h80
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  rx_data,
    input  logic        rx_empty,
    input  logic        rx_error,
    output logic        rx_read_strobe,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] word_count,
    output logic        halted
);

    localparam int unsigned WORD_W  = 10;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned COUNT_W = 16;
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HIGH     = 3'd1,
        LOW      = 3'd2,
        ERR_HIGH = 3'd3,
        ERR_LOW  = 3'd4,
        HALT     = 3'd5
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [WORD_W-1:0]   word;
    logic [BYTE_W-1:0]   err_code;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; out_valid is high in every byte state, so a transfer is out_ready alone
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (rx_error) begin
                    state_next = ERR_HIGH;
                end else if (!rx_empty) begin
                    state_next = HIGH;
                end
            end
            HIGH:     if (out_ready) state_next = LOW;
            LOW:      if (out_ready) state_next = IDLE;
            ERR_HIGH: if (out_ready) state_next = ERR_LOW;
            ERR_LOW:  if (out_ready) state_next = HALT;
            HALT:     state_next = HALT;
            default:  state_next = IDLE;
        endcase
    end

    // Output decode: byte path depends on state and latched registers only
    always_comb begin
        out_valid      = 1'b0;
        out_data       = '0;
        halted         = 1'b0;
        rx_read_strobe = 1'b0;
        case (state)
            IDLE: begin
                rx_read_strobe = !reset && !rx_error && !rx_empty;
            end
            HIGH: begin
                out_valid = 1'b1;
                out_data  = BYTE_W'({6'b0, word[WORD_W-1:BYTE_W]});
            end
            LOW: begin
                out_valid = 1'b1;
                out_data  = word[BYTE_W-1:0];
            end
            ERR_HIGH: begin
                out_valid = 1'b1;
                out_data  = ERROR_MARKER;
            end
            ERR_LOW: begin
                out_valid = 1'b1;
                out_data  = err_code;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    // Word/error capture and saturating delivered-word counter
    always_ff @(posedge clk) begin
        if (reset) begin
            word       <= '0;
            err_code   <= '0;
            word_count <= '0;
        end else begin
            if (state == IDLE) begin
                if (rx_error) begin
                    err_code <= rx_data[BYTE_W-1:0];
                end else if (!rx_empty) begin
                    word <= rx_data;
                end
            end
            if (state == LOW && out_ready && word_count != COUNT_MAX) begin
                word_count <= word_count + COUNT_W'(1);
            end
        end
    end

endmodule
